aes_inv_cipher: RTL
===================

Name: aes_inv_cipher

Overview:
Iterative AES-128 decryption core: the inverse of the team's sequential encryption datapath. Takes one 128-bit ciphertext block and produces the plaintext using the FIPS-197 inverse cipher (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), one sub-step per clock. Round keys come from an external key store through a zero-latency index/data lookup, so this block contains no key expansion. It sits beside the encryption core in the crypto datapath.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) supported, any other value is a configuration error.
RK_IDX_W, 4, width of the round-key index.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst_n  in  1  reset, synchronous, active-low.
read_enable  in  1  start request; sampled only in IDLE.
data_in  in  128  ciphertext; bits [127:120] = byte 0, column-major state (FIPS-197 order).
rk_idx  out  RK_IDX_W  round-key index requested this cycle (0..10).
rk_in  in  128  round key for rk_idx, valid in the same cycle (combinational lookup); same byte order.
busy  out  1  high while a block is in flight.
done  out  1  one-cycle pulse; data_out valid from this cycle on.
data_out  out  128  plaintext; held until the next done.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, round counter 0, busy=0, done=0, data_out=0, internal state register=0. Reset mid-operation aborts the block; no done is produced.
- FSM states: IDLE, INV_SHIFT, INV_SUB, ADD_KEY, INV_MIX, DONE.
- IDLE: rk_idx=10. If read_enable=1: st <= data_in ^ rk_in, round <= 9, busy <= 1, go to INV_SHIFT. Otherwise stay.
- INV_SHIFT: row r rotated right by r bytes (row 0 unchanged) -> INV_SUB.
- INV_SUB: every byte through the inverse S-box (table or GF(2^8) inverse plus inverse affine; the result must match the FIPS-197 inverse S-box) -> ADD_KEY.
- ADD_KEY: rk_idx=round; st <= st ^ rk_in. If round != 0 -> INV_MIX. If round == 0 -> DONE, and data_out <= st ^ rk_in in the same edge.
- INV_MIX: each column multiplied by {0e,0b,0d,09} circulant in GF(2^8), polynomial 0x11B; round <= round-1 -> INV_SHIFT.
- DONE: done=1 for exactly one cycle, busy <= 0 -> IDLE.
- rk_idx outside ADD_KEY/IDLE: holds last value (don't-care to the key store).
- Latency: start sampled at edge E0. Rounds 9..1 take 4 edges each (E1..E36); the final round takes 3 edges (E37..E39, no InvMixColumns). data_out is loaded at E39; done is high in the cycle after E39 and falls at E40. Next start is accepted at earliest in the IDLE cycle after DONE.
- read_enable while busy or in DONE: ignored, no queuing.
- data_in and rk_in are sampled only in the states listed above; they may change at any other time.

Optional Feature:
AES_DEC_MERGE_EN: when defined, INV_SHIFT and INV_SUB merge into one state (InvSubBytes applied to the InvShiftRows output in one cycle). Rounds 9..1 take 3 edges each and the final round takes 2. data_out loads at E29 and done is high in the following cycle. When not defined: separate states and timing as in Behaviour. Results are identical in both modes.

Test Plan:
1. Key 000102…0f, schedule from bench model, data_in 69c4e0d86a7b0430d8cdb78070b4c55a, read_enable 1 cycle -> data_out 00112233445566778899aabbccddeeff, done pulse exactly 1 cycle at the specified latency (30 with AES_DEC_MERGE_EN).
2. Key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734; rk_idx sequence 10,9,…,0 in ADD_KEY order.
3. Back-to-back: vector 2 started in the IDLE cycle right after vector 1's done -> both plaintexts correct; data_out holds vector 1 until vector 2's done.
4. read_enable held high throughout vector 1 with data_in changed mid-block -> single correct result; a second block starts only after returning to IDLE.
5. rst_n=0 for one cycle at round 5 of vector 1 -> busy=0, data_out=0, no done; a fresh start afterwards decrypts correctly.
6. All-zero key schedule, data_in 66e94bd4ef8a2c3b884cfa59ca342b2e -> data_out 00000000000000000000000000000000.

Source files
------------

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one FIPS-197 sub-step per clock; round keys come from an external store.
// Optional macro AES_DEC_MERGE_EN fuses InvShiftRows and InvSubBytes into a single state.
module aes_inv_cipher #(
  parameter int NR       = 10,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                read_enable,
  input  logic [127:0]        data_in,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_in,
  output logic                busy,
  output logic                done,
  output logic [127:0]        data_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INV_SHIFT = 3'd1,
    INV_SUB   = 3'd2,
    ADD_KEY   = 3'd3,
    INV_MIX   = 3'd4,
    DONE      = 3'd5
  } state_t;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map, then multiplicative inverse computed as y^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    logic [7:0] p;
    logic [7:0] r;
    for (int i = 0; i < 8; i++) b[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8];
    b = b ^ 8'h05;
    p = b;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                                gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09);
    end
    return o;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [127:0]        r_st, w_st_nxt, r_data_out, w_dout_nxt;
  logic [RK_IDX_W-1:0] r_round, w_round_nxt, r_rk_idx, w_rk_idx_nxt;
  logic                r_busy, w_busy_nxt, r_done;
  logic [127:0]        w_shift, w_sub_in, w_sub, w_mix, w_key;

  assign w_shift = inv_shift_rows(r_st);
`ifdef AES_DEC_MERGE_EN
  assign w_sub_in = w_shift;
`else
  assign w_sub_in = r_st;
`endif
  assign w_sub = inv_sub_bytes(w_sub_in);
  assign w_mix = inv_mix_columns(r_st);
  assign w_key = r_st ^ rk_in;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (read_enable) w_state_nxt = INV_SHIFT;
        else             w_state_nxt = IDLE;
      end
`ifdef AES_DEC_MERGE_EN
      INV_SHIFT: w_state_nxt = ADD_KEY;
`else
      INV_SHIFT: w_state_nxt = INV_SUB;
`endif
      INV_SUB: w_state_nxt = ADD_KEY;
      ADD_KEY: begin
        if (r_round == {RK_IDX_W{1'b0}}) w_state_nxt = DONE;
        else                             w_state_nxt = INV_MIX;
      end
      INV_MIX: w_state_nxt = INV_SHIFT;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_st_nxt    = r_st;
    w_round_nxt = r_round;
    w_busy_nxt  = r_busy;
    w_dout_nxt  = r_data_out;
    case (r_state)
      IDLE: begin
        if (read_enable) begin
          w_st_nxt    = data_in ^ rk_in;
          w_round_nxt = RK_IDX_W'(NR - 1);
          w_busy_nxt  = 1'b1;
        end else begin
          w_st_nxt    = r_st;
        end
      end
`ifdef AES_DEC_MERGE_EN
      INV_SHIFT: w_st_nxt = w_sub;
`else
      INV_SHIFT: w_st_nxt = w_shift;
`endif
      INV_SUB: w_st_nxt = w_sub;
      ADD_KEY: begin
        w_st_nxt = w_key;
        if (r_round == {RK_IDX_W{1'b0}}) w_dout_nxt = w_key;
        else                             w_dout_nxt = r_data_out;
      end
      INV_MIX: begin
        w_st_nxt    = w_mix;
        w_round_nxt = r_round - 1'b1;
      end
      DONE:    w_busy_nxt = 1'b0;
      default: w_busy_nxt = 1'b0;
    endcase
    // Index is registered, so it is presented on entry to the state that consumes rk_in.
    if (w_state_nxt == IDLE)         w_rk_idx_nxt = RK_IDX_W'(NR);
    else if (w_state_nxt == ADD_KEY) w_rk_idx_nxt = r_round;
    else                             w_rk_idx_nxt = r_rk_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_st       <= 128'h0;
      r_round    <= {RK_IDX_W{1'b0}};
      r_rk_idx   <= RK_IDX_W'(NR);
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= 128'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_st       <= w_st_nxt;
      r_round    <= w_round_nxt;
      r_rk_idx   <= w_rk_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= (w_state_nxt == DONE);
      r_data_out <= w_dout_nxt;
    end
  end

  assign rk_idx   = r_rk_idx;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;

endmodule
